flag_cond_unit: RTL and testbench

//   Consumer side of the ULA flag interface: latches O,C,S,Z after each ALU op,

---
 rtl/flag_cond_unit_if.sv | 32 +++
 rtl/flag_cond_unit.sv | 132 +++++++++++++
 tb/tb_flag_cond_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_cond_unit_if.sv
// Flag-unit bus: ALU flag inputs, branch-condition query/response and flag stack control.
//   master : ALU / control-unit side (drives ALU flags, queries, push/pop)
//   slave  : flag_cond_unit side (returns flags, cond_ack/cond_taken, stack errors)
interface flag_cond_unit_if;
  logic       alu_valid;
  logic [4:0] alu_op;
  logic       alu_o;
  logic       alu_c;
  logic       alu_s;
  logic       alu_z;
  logic [3:0] flags;
  logic       cond_req;
  logic [3:0] cond_code;
  logic       cond_ack;
  logic       cond_taken;
  logic       push;
  logic       pop;
  logic       stk_ovf;
  logic       stk_unf;

  modport master (
    output alu_valid, alu_op, alu_o, alu_c, alu_s, alu_z,
    output cond_req, cond_code, push, pop,
    input  flags, cond_ack, cond_taken, stk_ovf, stk_unf
  );

  modport slave (
    input  alu_valid, alu_op, alu_o, alu_c, alu_s, alu_z,
    input  cond_req, cond_code, push, pop,
    output flags, cond_ack, cond_taken, stk_ovf, stk_unf
  );
endinterface

// File: rtl/flag_cond_unit.sv
// Flag/condition unit: latches {O,C,S,Z} after each ALU op (only the flags the opcode
// affects), answers branch-condition queries one cycle after the request, and keeps a
// small flag save/restore stack for interrupt entry/exit.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : flag_cond_unit_if.slave (ALU flags in, condition query, push/pop, status out)
module flag_cond_unit #(
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  flag_cond_unit_if.slave bus
);

  localparam int unsigned SpW  = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]     flags_q;
  logic [3:0]     flags_d;
  logic [SpW-1:0] sp_q;
  logic [SpW-1:0] sp_d;
  logic           ack_q;
  logic           taken_q;
  logic           ovf_q;
  logic           unf_q;
  logic [3:0]     stack_q [DEPTH];

  logic [3:0]      mask;
  logic [3:0]      alu_flags;
  logic [3:0]      upd_flags;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;
  logic            ovf_set;
  logic            unf_set;
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] rd_idx;

  // Condition evaluation on {O,C,S,Z}.
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic o, c, s, z;
    o = f[3];
    c = f[2];
    s = f[1];
    z = f[0];
    case (code)
      4'h0:    return 1'b1;
      4'h1:    return z;
      4'h2:    return !z;
      4'h3:    return c;
      4'h4:    return !c;
      4'h5:    return s;
      4'h6:    return !s;
      4'h7:    return o;
      4'h8:    return !o;
      4'h9:    return !z && (s == o);
      4'hA:    return s == o;
      4'hB:    return s != o;
      4'hC:    return z || (s != o);
      4'hD:    return c && !z;
      4'hE:    return !c || z;
      default: return 1'b0;
    endcase
  endfunction

  // Which flags the opcode writes, as an {O,C,S,Z} mask.
  always_comb begin
    mask = 4'b0000;
    case (bus.alu_op)
      5'b00000, 5'b00001, 5'b00011,
      5'b00100, 5'b00101, 5'b00110: mask = 4'b1111;
      5'b01000, 5'b01001:           mask = 4'b0111;
      5'b10000:                     mask = 4'b0001;
      5'b11111:                     mask = 4'b0000;
      default: begin
        if (bus.alu_op >= 5'b10001) mask = 4'b0011;
      end
    endcase
  end

  always_comb begin
    full      = (sp_q == SpW'(DEPTH));
    empty     = (sp_q == '0);
    // Simultaneous push and pop cancel out: no stack movement, no error.
    do_push   = bus.push && !bus.pop && !full;
    do_pop    = bus.pop && !bus.push && !empty;
    ovf_set   = bus.push && !bus.pop && full;
    unf_set   = bus.pop && !bus.push && empty;
    wr_idx    = sp_q[IdxW-1:0];
    rd_idx    = IdxW'(sp_q - SpW'(1));
    alu_flags = {bus.alu_o, bus.alu_c, bus.alu_s, bus.alu_z};
    upd_flags = bus.alu_valid ? ((flags_q & ~mask) | (alu_flags & mask)) : flags_q;
    // A successful pop overrides any ALU update in the same cycle.
    flags_d   = do_pop ? stack_q[rd_idx] : upd_flags;
    sp_d      = sp_q;
    if (do_push) sp_d = sp_q + SpW'(1);
    else if (do_pop) sp_d = sp_q - SpW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
      sp_q    <= '0;
      ack_q   <= 1'b0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      sp_q    <= sp_d;
      ack_q   <= bus.cond_req;
      // Evaluated on flags_d so a same-cycle ALU op or pop is forwarded.
      if (bus.cond_req) taken_q <= eval_cond(bus.cond_code, flags_d);
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  // Stack contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) stack_q[wr_idx] <= flags_q;
  end

  assign bus.flags      = flags_q;
  assign bus.cond_ack   = ack_q;
  assign bus.cond_taken = taken_q;
  assign bus.stk_ovf    = ovf_q;
  assign bus.stk_unf    = unf_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed testbench for flag_cond_unit: flag update masks, condition forwarding,
// back-to-back queries, flag stack overflow/underflow and async reset.
module tb_flag_cond_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_fail;

  flag_cond_unit_if bus ();

  flag_cond_unit #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0;
    bus.alu_op    = 5'b0;
    bus.alu_o     = 1'b0;
    bus.alu_c     = 1'b0;
    bus.alu_s     = 1'b0;
    bus.alu_z     = 1'b0;
    bus.cond_req  = 1'b0;
    bus.cond_code = 4'h0;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] op, input logic [3:0] ocsz);
    bus.alu_valid = 1'b1;
    bus.alu_op    = op;
    {bus.alu_o, bus.alu_c, bus.alu_s, bus.alu_z} = ocsz;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({bus.flags, bus.cond_ack, bus.cond_taken, bus.stk_ovf, bus.stk_unf} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {bus.flags, bus.cond_ack, bus.cond_taken, bus.stk_ovf, bus.stk_unf});
    end
    reset = 1'b0;
  endtask

  task automatic test_update();
    logic [4:0] ops [6];
    logic [3:0] vals [6];
    logic [3:0] exps [6];
    // op, {O,C,S,Z} in, flags expected afterwards
    ops[0] = 5'b00101; vals[0] = 4'b0101; exps[0] = 4'b0101;
    ops[1] = 5'b10001; vals[1] = 4'b1010; exps[1] = 4'b0110;
    ops[2] = 5'b00000; vals[2] = 4'b0000; exps[2] = 4'b0000;
    ops[3] = 5'b01000; vals[3] = 4'b1101; exps[3] = 4'b0101;
    ops[4] = 5'b11111; vals[4] = 4'b1010; exps[4] = 4'b0101;
    ops[5] = 5'b10000; vals[5] = 4'b1110; exps[5] = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      drive_idle();
      drive_alu(ops[i], vals[i]);
      tick();
      n_vec++;
      if (bus.flags !== exps[i]) begin
        n_fail++;
        $display("FAIL update_%0d op=%b: flags got %b want %b", i, ops[i], bus.flags, exps[i]);
      end
    end
    // Undefined opcode and alu_valid=0 both leave flags alone.
    drive_idle();
    drive_alu(5'b00010, 4'b1011);
    tick();
    n_vec++;
    if (bus.flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL update_undef_op: flags got %b want 0100", bus.flags);
    end
    drive_idle();
    bus.alu_op = 5'b00000;
    {bus.alu_o, bus.alu_c, bus.alu_s, bus.alu_z} = 4'b1111;
    tick();
    n_vec++;
    if (bus.flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL update_not_valid: flags got %b want 0100", bus.flags);
    end
  endtask

  task automatic test_forward();
    drive_idle();
    drive_alu(5'b00000, 4'b0001);
    bus.cond_req  = 1'b1;
    bus.cond_code = 4'h1;
    tick();
    n_vec++;
    if ({bus.cond_ack, bus.cond_taken, bus.flags} !== 6'b11_0001) begin
      n_fail++;
      $display("FAIL forward_eq: ack/taken/flags got %b want 110001",
               {bus.cond_ack, bus.cond_taken, bus.flags});
    end
    drive_idle();
    tick();
    n_vec++;
    if ({bus.cond_ack, bus.cond_taken} !== 2'b01) begin
      n_fail++;
      $display("FAIL forward_hold: ack/taken got %b want 01", {bus.cond_ack, bus.cond_taken});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] codes [5];
    logic       exps [5];
    codes[0] = 4'hA; exps[0] = 1'b0;
    codes[1] = 4'hB; exps[1] = 1'b1;
    codes[2] = 4'hC; exps[2] = 1'b1;
    codes[3] = 4'h0; exps[3] = 1'b1;
    codes[4] = 4'hF; exps[4] = 1'b0;
    drive_idle();
    drive_alu(5'b00000, 4'b0010);
    tick();
    drive_idle();
    for (int i = 0; i < 5; i++) begin
      bus.cond_req  = 1'b1;
      bus.cond_code = codes[i];
      tick();
      n_vec++;
      if ({bus.cond_ack, bus.cond_taken} !== {1'b1, exps[i]}) begin
        n_fail++;
        $display("FAIL b2b_code_%h: ack/taken got %b want %b", codes[i],
                 {bus.cond_ack, bus.cond_taken}, {1'b1, exps[i]});
      end
    end
    drive_idle();
  endtask

  task automatic test_all_conds();
    logic [3:0]  fl [2];
    logic [15:0] ex [2];
    logic [15:0] e;
    // Bit n of ex is the expected outcome of condition code n.
    fl[0] = 4'b0101; ex[0] = 16'h554B;
    fl[1] = 4'b1010; ex[1] = 16'h46B5;
    for (int k = 0; k < 2; k++) begin
      e = ex[k];
      drive_idle();
      drive_alu(5'b00000, fl[k]);
      tick();
      drive_idle();
      for (int c = 0; c < 16; c++) begin
        bus.cond_req  = 1'b1;
        bus.cond_code = 4'(c);
        tick();
        n_vec++;
        if ({bus.cond_ack, bus.cond_taken} !== {1'b1, e[c]}) begin
          n_fail++;
          $display("FAIL cond_f%b_code_%0d: ack/taken got %b want %b", fl[k], c,
                   {bus.cond_ack, bus.cond_taken}, {1'b1, e[c]});
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_stack();
    logic [3:0] vals [5];
    logic [3:0] pops [4];
    vals[0] = 4'b0010; vals[1] = 4'b0100; vals[2] = 4'b1000;
    vals[3] = 4'b0011; vals[4] = 4'b0110;
    pops[0] = 4'b1000; pops[1] = 4'b0100; pops[2] = 4'b0010; pops[3] = 4'b0001;
    do_reset();
    drive_alu(5'b00000, 4'b0001);
    tick();
    // Each push saves the old flags while the ALU update still lands.
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      drive_alu(5'b00000, vals[i]);
      bus.push = 1'b1;
      tick();
      n_vec++;
      if ({bus.flags, bus.stk_ovf} !== {vals[i], (i == 4)}) begin
        n_fail++;
        $display("FAIL push_%0d: flags/ovf got %b want %b", i, {bus.flags, bus.stk_ovf},
                 {vals[i], (i == 4)});
      end
    end
    // Push and pop together: nothing moves, no error.
    drive_idle();
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    tick();
    n_vec++;
    if ({bus.flags, bus.stk_unf} !== 5'b0110_0) begin
      n_fail++;
      $display("FAIL push_pop_same: flags/unf got %b want 01100", {bus.flags, bus.stk_unf});
    end
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      bus.pop = 1'b1;
      tick();
      n_vec++;
      if ({bus.flags, bus.stk_unf, bus.stk_ovf} !== {pops[i], 2'b01}) begin
        n_fail++;
        $display("FAIL pop_%0d: flags/unf/ovf got %b want %b", i,
                 {bus.flags, bus.stk_unf, bus.stk_ovf}, {pops[i], 2'b01});
      end
    end
    // Empty pop: ignored, ALU update (Z only) still applied.
    drive_idle();
    bus.pop = 1'b1;
    drive_alu(5'b10000, 4'b1110);
    tick();
    n_vec++;
    if ({bus.flags, bus.stk_unf, bus.stk_ovf} !== 6'b0000_11) begin
      n_fail++;
      $display("FAIL pop_empty: flags/unf/ovf got %b want 000011",
               {bus.flags, bus.stk_unf, bus.stk_ovf});
    end
    drive_idle();
  endtask

  task automatic test_pop_priority_and_reset();
    do_reset();
    drive_alu(5'b00000, 4'b0011);
    tick();
    drive_idle();
    bus.push = 1'b1;
    drive_alu(5'b00000, 4'b1100);
    tick();
    drive_idle();
    bus.pop = 1'b1;
    drive_alu(5'b00000, 4'b1111);
    bus.cond_req  = 1'b1;
    bus.cond_code = 4'h2;
    tick();
    n_vec++;
    if ({bus.flags, bus.cond_ack, bus.cond_taken} !== 6'b0011_10) begin
      n_fail++;
      $display("FAIL pop_beats_alu: flags/ack/taken got %b want 001110",
               {bus.flags, bus.cond_ack, bus.cond_taken});
    end
    drive_idle();
    bus.pop = 1'b1;
    bus.cond_req  = 1'b1;
    bus.cond_code = 4'h0;
    tick();
    n_vec++;
    if ({bus.cond_ack, bus.cond_taken, bus.stk_unf} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset_state: ack/taken/unf got %b want 111",
               {bus.cond_ack, bus.cond_taken, bus.stk_unf});
    end
    drive_idle();
    bus.cond_req = 1'b1;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.flags, bus.cond_ack, bus.cond_taken, bus.stk_ovf, bus.stk_unf} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 00000000",
               {bus.flags, bus.cond_ack, bus.cond_taken, bus.stk_ovf, bus.stk_unf});
    end
    tick();
    n_vec++;
    if (bus.cond_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pending: ack got %b want 0", bus.cond_ack);
    end
    drive_idle();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    drive_idle();
    test_reset();
    test_update();
    test_forward();
    test_back_to_back();
    test_all_conds();
    test_stack();
    test_pop_priority_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
